sistema_speed_core: RTL and testbench

- Single-bit full-adder cell with registered outputs, used as the add primitive in the hash datapath.
- Sums three 1-bit operands (a, b, c) and produces sum s and carry-out carry.
- Combinational adder core followed by one output register stage, qualified by a valid strobe.
- Synchronous, active-low reset.

---
 rtl/sistema_speed_core.sv | 58 +++++
 tb/tb_sistema_speed_core.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sistema_speed_core.sv
// Single-bit full adder (a + b + c -> {carry, s}) with an optional output
// register stage and a registered valid strobe.
module sistema_speed_core #(
  parameter int REGISTERED = 1
) (
  input  logic clk,
  input  logic reset_L,
  input  logic valid_in,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic carry,
  output logic valid_out
);

  logic sum_c;
  logic carry_c;
  logic valid_q;

  always_comb begin
    sum_c   = a ^ b ^ c;
    carry_c = (a & b) | (a & c) | (b & c);
  end

  // valid_out is registered in both build variants.
  always_ff @(posedge clk) begin
    if (!reset_L) valid_q <= 1'b0;
    else          valid_q <= valid_in;
  end

  assign valid_out = valid_q;

  generate
    if (REGISTERED != 0) begin : g_reg
      logic s_q;
      logic carry_q;

      // Result loads only on accepted operands; otherwise the last result is held.
      always_ff @(posedge clk) begin
        if (!reset_L) begin
          s_q     <= 1'b0;
          carry_q <= 1'b0;
        end else if (valid_in) begin
          s_q     <= sum_c;
          carry_q <= carry_c;
        end
      end

      assign s     = s_q;
      assign carry = carry_q;
    end else begin : g_comb
      assign s     = sum_c;
      assign carry = carry_c;
    end
  endgenerate

endmodule

// File: tb/tb_sistema_speed_core.sv
// Scoreboard bench for sistema_speed_core: registered and combinational builds
// share one stimulus stream; expected {valid_out, carry, s} are hand-computed.
module tb_sistema_speed_core;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic valid_in = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c = 1'b0;
  logic s_r, carry_r, vo_r;
  logic s_c, carry_c, vo_c;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  // Truth table for {a,b,c} = 0..7 as {carry, s}.
  logic [1:0] sweep_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  always #5 clk = ~clk;

  sistema_speed_core #(.REGISTERED(1)) dut_reg (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in),
    .a(a), .b(b), .c(c),
    .s(s_r), .carry(carry_r), .valid_out(vo_r)
  );

  sistema_speed_core #(.REGISTERED(0)) dut_comb (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in),
    .a(a), .b(b), .c(c),
    .s(s_c), .carry(carry_c), .valid_out(vo_c)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic rn, input logic v, input logic [2:0] abc,
                      input logic evo, input logic [1:0] ecs);
    @(negedge clk);
    reset_L  = rn;
    valid_in = v;
    {a, b, c} = abc;
    exp_q.push_back({evo, ecs});
  endtask

  // Monitor: compares every queued expectation just after the active edge.
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check1("valid_out", vo_r, e[2]);
        check1("carry", carry_r, e[1]);
        check1("s", s_r, e[0]);
        check1("comb_valid_out", vo_c, e[2]);
      end
    end
  end

  initial begin
    // Reset held two cycles with all operands high and valid asserted.
    step(1'b0, 1'b1, 3'b111, 1'b0, 2'b00);
    step(1'b0, 1'b1, 3'b111, 1'b0, 2'b00);

    // Exhaustive back-to-back sweep.
    for (int unsigned i = 0; i < 8; i++) begin
      logic [2:0] v3;
      v3 = i[2:0];
      step(1'b1, 1'b1, v3, 1'b1, sweep_exp[i]);
    end

    // Hold: result persists while valid_in is low.
    step(1'b1, 1'b1, 3'b111, 1'b1, 2'b11);
    step(1'b1, 1'b0, 3'b000, 1'b0, 2'b11);
    step(1'b1, 1'b0, 3'b000, 1'b0, 2'b11);

    // Repeat input.
    step(1'b1, 1'b1, 3'b111, 1'b1, 2'b11);
    step(1'b1, 1'b1, 3'b111, 1'b1, 2'b11);

    // Reset mid-stream at input 110, then resume with 011.
    for (int unsigned i = 0; i < 6; i++) begin
      logic [2:0] v3;
      v3 = i[2:0];
      step(1'b1, 1'b1, v3, 1'b1, sweep_exp[i]);
    end
    step(1'b0, 1'b1, 3'b110, 1'b0, 2'b00);
    step(1'b1, 1'b1, 3'b011, 1'b1, 2'b10);
    step(1'b1, 1'b0, 3'b101, 1'b0, 2'b10);
    step(1'b1, 1'b1, 3'b100, 1'b1, 2'b01);
    step(1'b1, 1'b0, 3'b000, 1'b0, 2'b01);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    // Combinational build: outputs follow inputs regardless of reset/valid.
    @(negedge clk);
    reset_L  = 1'b0;
    valid_in = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      logic [2:0] v3;
      v3 = i[2:0];
      {a, b, c} = v3;
      #0.5;
      check1("comb_carry", carry_c, sweep_exp[i][1]);
      check1("comb_s", s_c, sweep_exp[i][0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
